// File: rtl/to_montgomery_serial_pkg.sv
// Shared constants and FSM state type for the normal-to-Montgomery converter.
// params_pkg carries the datapath and modulus defaults; multiplier_pkg carries the state enum.
package params_pkg;
  localparam int unsigned DATA_LENGTH    = 32;
  localparam int unsigned MODULUS        = 8380417;
  localparam int unsigned MODULUS_LENGTH = 23;
  localparam int unsigned CNT_WIDTH      = $clog2(2 * DATA_LENGTH + 1);
endpackage

package multiplier_pkg;
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } to_mont_state_t;
endpackage

// File: rtl/mod_double_add_step.sv
// One bit-serial reduction step: r' = (2r + b) mod m, assuming r < m on entry.
module mod_double_add_step #(
  parameter int unsigned DATA_LENGTH = params_pkg::DATA_LENGTH
) (
  input  logic [DATA_LENGTH:0]   r,
  input  logic                   b,
  input  logic [DATA_LENGTH-1:0] m,
  output logic [DATA_LENGTH:0]   r_next
);
  localparam int unsigned TW = DATA_LENGTH + 2;

  logic [TW-1:0]        t;
  logic [DATA_LENGTH:0] diff;

  // The extra top bit of t keeps the compare exact even if r were out of range.
  assign t      = {r, b};
  assign diff   = t[DATA_LENGTH:0] - {1'b0, m};
  assign r_next = (t >= TW'(m)) ? diff : t[DATA_LENGTH:0];
endmodule

// File: rtl/to_montgomery_serial.sv
// Bit-serial conversion xm = x * 2^k mod m, result held under a valid/ready handshake.
// Optional configuration checking (err_o) is enabled by defining TO_MONT_CHECK_EN.
module to_montgomery_serial
  import multiplier_pkg::*;
#(
  parameter int unsigned DATA_LENGTH = params_pkg::DATA_LENGTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [DATA_LENGTH-1:0] x_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  input  logic [DATA_LENGTH-1:0] m_bl_i,
  input  logic                   ready_i,
  output logic                   busy_o,
  output logic [DATA_LENGTH-1:0] result_o,
  output logic                   valid_o,
  output logic                   err_o
);
  localparam int unsigned CW = $clog2(2 * DATA_LENGTH + 1);
  localparam int unsigned KW = $clog2(DATA_LENGTH + 1);

  to_mont_state_t         state_q, state_d;
  logic [DATA_LENGTH-1:0] x_q, x_d;
  logic [DATA_LENGTH-1:0] m_q, m_d;
  logic [DATA_LENGTH:0]   r_q, r_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_LENGTH-1:0] result_q, result_d;
  logic                   busy_q, busy_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic [DATA_LENGTH:0]   step_r;
  logic [KW-1:0]          k;
  logic                   cfg_bad_c;
  logic                   unused_mbl;

  assign k          = m_bl_i[KW-1:0];
  assign unused_mbl = ^m_bl_i[DATA_LENGTH-1:KW];

`ifdef TO_MONT_CHECK_EN
  always_comb begin
    cfg_bad_c = ~m_i[0]
              | (m_i == '0)
              | (k == '0)
              | (k > KW'(DATA_LENGTH - 1))
              | ((m_i >> k) != '0);
  end
`else
  assign cfg_bad_c = 1'b0;
`endif

  // x is shifted out MSB first; once exhausted the shift register feeds the k zero bits.
  mod_double_add_step #(
    .DATA_LENGTH(DATA_LENGTH)
  ) u_step (
    .r      (r_q),
    .b      (x_q[DATA_LENGTH-1]),
    .m      (m_q),
    .r_next (step_r)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      x_q      <= '0;
      m_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      m_q      <= m_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    m_d      = m_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          x_d    = x_i;
          m_d    = m_i;
          r_d    = '0;
          cnt_d  = CW'(DATA_LENGTH) + CW'(k);
          busy_d = 1'b1;
          if (cfg_bad_c) begin
            state_d  = DONE;
            result_d = '0;
            valid_d  = 1'b1;
            err_d    = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d   = step_r;
        x_d   = {x_q[DATA_LENGTH-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = DONE;
          result_d = step_r[DATA_LENGTH-1:0];
          valid_d  = 1'b1;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o   = busy_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign err_o    = err_q;
endmodule

// File: doc/to_montgomery_serial.md
# to_montgomery_serial

Bit-serial converter from the normal domain into the Montgomery domain. It computes xm = x·2^m_bl mod m for an arbitrary DATA_LENGTH-bit operand x. It sits directly upstream of montgomery_parallel_top and drives its x_i, reusing the same modulus, bit-length and start/valid conventions. It holds its result under a downstream valid/ready handshake.

## Interface
Parameters:
- DATA_LENGTH, default params_pkg::DATA_LENGTH: operand, modulus and result width.

Ports:
- clk_i, in, 1: single clock; all logic is rising-edge.
- rst_ni, in, 1: reset, asynchronous and active-low.
- start_i, in, 1: request conversion. Sampled only in IDLE.
- x_i, in, DATA_LENGTH: normal-domain operand. Any value is allowed; x ≥ m is legal.
- m_i, in, DATA_LENGTH: modulus. Must be odd and < 2^(DATA_LENGTH-1).
- m_bl_i, in, DATA_LENGTH: modulus bit length k, so R = 2^k. Only bits [$clog2(DATA_LENGTH+1)-1:0] are used.
- ready_i, in, 1: downstream can accept result_o.
- busy_o, out, 1: high from start acceptance until the handshake completes.
- result_o, out, DATA_LENGTH: x·2^k mod m.
- valid_o, out, 1: result_o is valid. Held until ready_i.
- err_o, out, 1: invalid configuration. Active only with the macro below.

## Operation
- The FSM has states IDLE, RUN and DONE.
- **IDLE, start_i=1:**
  - Latch x, m and k.
  - Clear the accumulator r (DATA_LENGTH+1 bits).
  - Set the iteration counter to N = DATA_LENGTH + k.
  - Go to RUN.
- **RUN, one iteration per cycle:** t = 2r + b, then r = (t ≥ m) ? t − m : t.
  - For the first DATA_LENGTH iterations, b is the bits of x, MSB first.
  - For the remaining k iterations, b = 0.
- **Invariant:** r < m after every iteration. This needs the extra accumulator bit, since t < 2m ≤ 2^DATA_LENGTH.
- **Counter reaches 0:** go to DONE, drive result_o = r[DATA_LENGTH-1:0], set valid_o=1.
- **DONE:**
  - On valid_o & ready_i at a rising edge, go to IDLE and clear valid_o.
  - result_o stays stable while valid_o=1 and ready_i=0.
- **start_i ignored:** in RUN and DONE, including the handshake cycle. It is not queued.
- **k=0:** N = DATA_LENGTH, so the result is x mod m.
- Inputs are not re-sampled after acceptance. Changing them mid-operation has no effect.

## Timing
- **Reset values:** state IDLE; busy_o=0, valid_o=0, err_o=0, result_o=0; accumulator and counter 0.
- **Reset mid-operation:** the FSM returns to IDLE asynchronously and all outputs take their reset values. The aborted result is never presented.
- **Start acceptance:** start is accepted at edge E0; busy_o=1 is visible after E0.
- **Iterations:** they occur at edges E1..EN.
- **Completion:** valid_o=1 after edge EN. Latency from E0 to valid_o is N = DATA_LENGTH + k cycles.
- **Handshake edge:** valid_o and busy_o fall after the edge at which valid_o & ready_i = 1.
- **Back-to-back:** the earliest next start is accepted the cycle after returning to IDLE.
- **Combinational paths:** none from inputs to outputs.

## Configuration
Macro: TO_MONT_CHECK_EN.

- **Defined:** at start acceptance, the block checks the configuration. The following are invalid:
  - m_i even,
  - m_i = 0,
  - k = 0,
  - k > DATA_LENGTH-1,
  - m_i ≥ 2^k.

  On an invalid configuration, skip RUN and go straight to DONE with result_o=0 and err_o=1; valid_o rises after E0. err_o clears with valid_o.
- **Not defined:** no checking is performed and err_o is tied 0. Behaviour with an invalid modulus is undefined.

## Structure
- **params_pkg:** DATA_LENGTH, MODULUS, MODULUS_LENGTH. Also add a derived constant for the counter width, $clog2(2·DATA_LENGTH+1).
- **multiplier_pkg:** typedef enum to_mont_state_t {IDLE, RUN, DONE}.
- **Sub-module mod_double_add_step:** combinational (r, b, m) → reduced r'. The FSM, counter and handshake stay in the top.

## Test plan
Configuration for all scenarios: DATA_LENGTH=32, m=8380417 (Dilithium q), k=23, so R mod q = 8191.

1. **Basic conversion:** x=1, ready_i=1 → valid_o rises exactly 55 cycles after start acceptance, result_o=0x00001FFF. Then x=2 → 16382.
2. **Reduction edge cases:**
   - x=0 → 0.
   - x=q → 0.
   - x=q+1 → 8191.
   - x=0xFFFFFFFF → (0xFFFFFFFF·2^23) mod q, checked against the bench model.
3. **Round-trip:** for every value in dilithium_input.txt, feed result_o into montgomery_parallel_top → its result_o equals x mod q.
4. **Backpressure and ignored start:**
   - Hold ready_i=0 for 10 cycles after valid_o rises → valid_o and result_o stay constant and busy_o stays 1.
   - Pulse start_i during RUN and during DONE → no second conversion occurs.
   - Raise ready_i → valid_o and busy_o fall after the next edge.
5. **Reset mid-operation:** deassert rst_ni 20 cycles into RUN, asynchronously → all outputs are 0 immediately. A subsequent x=1 conversion yields 8191 with normal latency.
6. **Configuration checking (TO_MONT_CHECK_EN defined):**
   - m=8380416 (even) → valid_o=1 and err_o=1 after E0, result_o=0.
   - k=0 → same response.
   - Without the macro, err_o stays 0 throughout.
